// File: rtl/jk_bank_programmer.sv
// jk_bank_programmer: write-side driver for a bank of JK flip-flops.
// Accepts a target word, drives one cycle of J/K excitation derived from the
// bank's fed-back Q, waits for the bank to settle, verifies, and retries on
// mismatch until the retry budget is spent.
module jk_bank_programmer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SETTLE    = 1,
   parameter int unsigned MAX_RETRY = 2,
   parameter bit          DC_ONE    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam int unsigned SW = $clog2(SETTLE + 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] tgt;
   logic [RW-1:0]    retry_cnt;
   logic [SW-1:0]    settle_cnt;

   // J term: set where needed; with DC_ONE the don't-care (q=1) resolves to 1
   function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] t);
      return DC_ONE ? (q | t) : (~q & t);
   endfunction

   // K term: reset where needed; with DC_ONE the don't-care (q=0) resolves to 1
   function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] t);
      return DC_ONE ? ~(q & t) : (q & ~t);
   endfunction

   assign tgt_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // Sequencer: accept, drive one cycle, settle, verify, retry or finish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tgt        <= '0;
         retry_cnt  <= '0;
         settle_cnt <= '0;
         j_out      <= '0;
         k_out      <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tgt_valid) begin
                  tgt       <= tgt_data;
                  err       <= 1'b0;
                  retry_cnt <= '0;
                  j_out     <= exc_j(q_fb, tgt_data);
                  k_out     <= exc_k(q_fb, tgt_data);
                  state     <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               j_out      <= '0;
               k_out      <= '0;
               settle_cnt <= SETTLE_LD;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (settle_cnt == '0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               if (q_fb == tgt) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else if (retry_cnt < RETRY_LIM) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  j_out     <= exc_j(q_fb, tgt);
                  k_out     <= exc_k(q_fb, tgt);
                  state     <= ST_DRIVE;
               end else begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   generate
      if (!DC_ONE) begin : g_excl
         // Without toggle-preferred resolution J and K are never both high
         always @(posedge clk) begin
            if (!rst) assert ((j_out & k_out) == '0);
         end
      end
   endgenerate

endmodule

// File: tb/tb_jk_bank_programmer.sv
// Bench for jk_bank_programmer: two instances (toggle-free, SETTLE=1 and
// toggle-preferred, SETTLE=3) each driving a behavioural JK bank, checked
// cycle by cycle against a transaction-level reference model.
module tb_jk_bank_programmer;

   logic       clk;
   logic       rst;
   logic       tgt_valid  [2];
   logic       tgt_ready  [2];
   logic [3:0] tgt_data   [2];
   logic [3:0] bank       [2];
   logic [3:0] j_out      [2];
   logic [3:0] k_out      [2];
   logic       busy       [2];
   logic       done       [2];
   logic       err        [2];
   logic       preset     [2];
   logic [3:0] preset_val [2];
   logic [3:0] stuck      [2];

   int total;
   int bad;

   jk_bank_programmer #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .DC_ONE(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]), .tgt_data(tgt_data[0]),
      .q_fb(bank[0]), .j_out(j_out[0]), .k_out(k_out[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]));

   jk_bank_programmer #(.WIDTH(4), .SETTLE(3), .MAX_RETRY(2), .DC_ONE(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]), .tgt_data(tgt_data[1]),
      .q_fb(bank[1]), .j_out(j_out[1]), .k_out(k_out[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // JK register banks (not reset by rst); stuck bits read as 0
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (preset[i]) bank[i] <= preset_val[i];
         else bank[i] <= ((j_out[i] & ~bank[i]) | (~k_out[i] & bank[i])) & ~stuck[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference excitation: hold where equal, otherwise set/reset; toggle for don't-cares if dc
   function automatic logic [7:0] ref_exc(input bit dc, input logic [3:0] q, input logic [3:0] t);
      logic [3:0] j, k;
      for (int b = 0; b < 4; b++) begin
         if (q[b] == t[b]) begin
            j[b] = dc ? t[b] : 1'b0;
            k[b] = dc ? ~t[b] : 1'b0;
         end else if (t[b]) begin
            j[b] = 1'b1;
            k[b] = dc;
         end else begin
            j[b] = dc;
            k[b] = 1'b1;
         end
      end
      return {j, k};
   endfunction

   // Reference JK behaviour: both=toggle, J=set, K=reset, none=hold
   function automatic logic [3:0] ref_apply(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
      logic [3:0] r;
      for (int b = 0; b < 4; b++) begin
         if (j[b] && k[b]) r[b] = ~q[b];
         else if (j[b]) r[b] = 1'b1;
         else if (k[b]) r[b] = 1'b0;
         else r[b] = q[b];
      end
      return r;
   endfunction

   task automatic load(input int i, input logic [3:0] v);
      preset[i] = 1'b1;
      preset_val[i] = v;
      @(posedge clk);
      @(negedge clk);
      preset[i] = 1'b0;
   endtask

   // One transaction, called and returning at a negedge; returns in the cycle
   // after completion (done/err visible, ready high) so calls chain back-to-back
   task automatic txn(input int i, input logic [3:0] t, input bit hold);
      logic [3:0] q;
      logic [3:0] ej [3];
      logic [3:0] ek [3];
      logic [7:0] jk;
      int att, p, term;
      bit ok;
      p = (i == 0) ? 3 : 5;
      q = bank[i];
      ok = 1'b0;
      att = 0;
      for (int a = 0; a < 3 && !ok; a++) begin
         jk = ref_exc(i == 1, q, t);
         ej[a] = jk[7:4];
         ek[a] = jk[3:0];
         q = ref_apply(q, ej[a], ek[a]) & ~stuck[i];
         att = a + 1;
         ok = (q == t);
      end
      term = att * p;
      chk("ready_at_offer", 32'(tgt_ready[i]), 32'd1);
      tgt_valid[i] = 1'b1;
      tgt_data[i] = t;
      @(posedge clk);
      for (int n = 0; n <= term; n++) begin
         logic [3:0] xj, xk;
         @(negedge clk);
         if (n != term) begin
            if (hold) tgt_data[i] = 4'($urandom);
            else tgt_valid[i] = 1'b0;
         end
         xj = '0;
         xk = '0;
         if ((n % p) == 0 && (n / p) < att) begin
            xj = ej[n / p];
            xk = ek[n / p];
         end
         chk("j_out", 32'(j_out[i]), 32'(xj));
         chk("k_out", 32'(k_out[i]), 32'(xk));
         chk("busy", 32'(busy[i]), 32'(n != term));
         chk("done", 32'(done[i]), 32'(n == term && ok));
         chk("err", 32'(err[i]), 32'(n == term && !ok));
      end
      chk("ready_after", 32'(tgt_ready[i]), 32'd1);
      chk("bank_q", 32'(bank[i]), 32'(q));
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tgt_valid[i] = 1'b0;
         tgt_data[i] = '0;
         preset[i] = 1'b0;
         preset_val[i] = '0;
         stuck[i] = '0;
      end
      @(negedge clk);
      load(0, 4'b0000);
      load(1, 4'b0000);
      for (int i = 0; i < 2; i++) begin
         chk("rst_j", 32'(j_out[i]), 32'd0);
         chk("rst_k", 32'(k_out[i]), 32'd0);
         chk("rst_done", 32'(done[i]), 32'd0);
         chk("rst_err", 32'(err[i]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rel_busy", 32'(busy[i]), 32'd0);
         chk("rel_ready", 32'(tgt_ready[i]), 32'd1);
      end

      // set from zero, then back-to-back retarget
      txn(0, 4'b1010, 1'b0);
      txn(0, 4'b0110, 1'b0);
      txn(0, 4'b0110, 1'b0);

      // toggle-preferred retarget and hold-equivalent target with long settle
      load(1, 4'b1010);
      txn(1, 4'b0110, 1'b0);
      load(1, 4'b0101);
      txn(1, 4'b0101, 1'b0);

      // stuck-at-0 bit: three drives then sticky error, cleared by next target
      stuck[0] = 4'b0001;
      load(0, 4'b0000);
      txn(0, 4'b0001, 1'b0);
      chk("err_sticky", 32'(err[0]), 32'd1);
      @(negedge clk);
      chk("err_still", 32'(err[0]), 32'd1);
      stuck[0] = 4'b0000;
      txn(0, 4'b0011, 1'b0);

      // valid held high with changing data on both instances
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 6; r++) txn(i, 4'($urandom), 1'b1);
         tgt_valid[i] = 1'b0;
         @(negedge clk);
         chk("held_idle", 32'(busy[i]), 32'd0);
      end

      // random targets with occasional stuck bits
      for (int r = 0; r < 16; r++) begin
         int i;
         i = r % 2;
         stuck[i] = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
         load(i, 4'($urandom) & ~stuck[i]);
         txn(i, 4'($urandom), 1'b0);
      end
      stuck[0] = '0;
      stuck[1] = '0;

      // reset during the drive cycle
      load(0, 4'b0000);
      tgt_valid[0] = 1'b1;
      tgt_data[0] = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      tgt_valid[0] = 1'b0;
      chk("abort_j_pre", 32'(j_out[0]), 32'hF);
      chk("abort_k_pre", 32'(k_out[0]), 32'h0);
      rst = 1'b1;
      #1;
      chk("abort_j", 32'(j_out[0]), 32'h0);
      chk("abort_k", 32'(k_out[0]), 32'h0);
      chk("abort_done", 32'(done[0]), 32'd0);
      chk("abort_err", 32'(err[0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_ready", 32'(tgt_ready[0]), 32'd1);
      chk("abort_bank", 32'(bank[0]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_done2", 32'(done[0]), 32'd0);
      chk("abort_err2", 32'(err[0]), 32'd0);
      chk("abort_bank2", 32'(bank[0]), 32'h0);
      txn(0, 4'b1001, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_bank_programmer.md
Name: jk_bank_programmer

Overview:
- Write-side driver for a bank of WIDTH JK flip-flops.
- Accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the bank's current Q (fed back) and the target.
- Drives J/K for exactly one clock, waits for the bank to settle, then verifies Q against the target.
- Retries on mismatch and flags an error after exhausting retries; sits between control logic and any JK register bank in the design.

Parameters:
- WIDTH, 8, number of JK flip-flops in the bank.
- SETTLE, 1, cycles waited after the drive edge before comparing q_fb (minimum 1).
- MAX_RETRY, 2, additional drive attempts after the first before error.
- DC_ONE, 0, resolution of don't-care excitation terms: 0 = don't-care→0 (hold/set/reset only); 1 = don't-care→1 (toggle-preferred).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tgt_valid  input  1  target word valid.
- tgt_ready  output  1  block can accept a target (high only in IDLE).
- tgt_data  input  WIDTH  desired bank state.
- q_fb  input  WIDTH  current Q of the JK bank.
- j_out  output  WIDTH  J inputs to bank (registered).
- k_out  output  WIDTH  K inputs to bank (registered).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: bank verified equal to target.
- err  output  1  sticky error; set on retry exhaustion, cleared on next accepted target.

Behaviour:
- Reset (async, immediate): state=IDLE; j_out=k_out=0; done=0; err=0; retry count=0; latched target=0. tgt_ready=1, busy=0 after reset releases.
- States: IDLE, DRIVE, WAIT, CHECK.
- IDLE:
  - tgt_ready=1.
  - On an edge with tgt_valid&tgt_ready: latch tgt_data, clear err, retry count=0, load j_out/k_out from the excitation of q_fb (sampled at that edge) and tgt_data; →DRIVE.
- Excitation per bit (q = q_fb bit, t = target bit):
  - DC_ONE=0: j = ~q&t, k = q&~t.
  - DC_ONE=1: j = q|t, k = ~(q&t).
- DRIVE:
  - j_out/k_out are valid for exactly this one cycle; the bank samples them at the closing edge.
  - At that edge j_out/k_out return to 0 (hold); load settle counter; →WAIT.
- WAIT:
  - j_out=k_out=0.
  - Stays SETTLE-1 further cycles, so SETTLE=1 means one WAIT cycle; then →CHECK.
- CHECK (single cycle, compare q_fb == latched target):
  - Match: done=1 for the following cycle; →IDLE.
  - Mismatch and retry count < MAX_RETRY: increment count, reload j_out/k_out from current q_fb and the target; →DRIVE.
  - Mismatch and retry count == MAX_RETRY: err=1 (sticky); no done; →IDLE.
- Latency: acceptance edge E0. Bank updates at E1. With SETTLE=1, CHECK occupies the cycle after E2. On match, done is high in the cycle after E3 and tgt_ready is high in that same cycle.
- tgt_valid while busy: ignored (tgt_ready=0); tgt_data is not re-sampled during an operation.
- Target equal to current q_fb: the normal sequence still runs. Excitation is all-zero for DC_ONE=0; for DC_ONE=1 it is j = ~k per bit (q=t=1 → j=1,k=0; q=t=0 → j=0,k=1), which is hold-equivalent and must not toggle. done is still reported.
- done and acceptance of a new target can occur on the same cycle (back-to-back).
- Reset mid-operation: j_out/k_out are forced to 0 asynchronously, so no partial excitation reaches the bank. The in-flight transaction is dropped; no done, no err.
- j_out&k_out may be 1 only when DC_ONE=1; with DC_ONE=0, j_out&k_out==0 always (assertion).

Test Plan:
- WIDTH=4, DC_ONE=0, bank model Q=0000, send tgt_data=1010 → j_out=1010, k_out=0000 for one cycle; Q=1010; done pulse 3 cycles after acceptance edge; err=0.
- From Q=1010, DC_ONE=0, send 0110 → j_out=0100, k_out=1000 for one cycle; done. Repeat with DC_ONE=1 → j_out=1110, k_out=1101; Q=0110; done.
- Bank model with bit0 stuck at 0, MAX_RETRY=2, target 0001 → three DRIVE cycles each with j_out[0]=1; no done; err=1 after third CHECK; err clears on next accepted target.
- tgt_valid held high continuously with changing data → only words presented while tgt_ready=1 are accepted; one transaction per done; back-to-back acceptance on done cycle.
- Assert rst during DRIVE (j_out nonzero) → j_out=k_out=0 immediately, busy=0 and tgt_ready=1 after release, no done/err, bank Q unchanged by the aborted cycle.
- SETTLE=3, target equal to current Q=0101 with DC_ONE=1 → j_out=0101, k_out=1010 (hold-equivalent), Q unchanged, done 5 cycles after acceptance.
